sqr_mul: RTL and testbench
==========================

# sqr_mul

Iterative shift-add squarer: latches an unsigned 8-bit operand on `start_i` and returns its 16-bit square on `y_bo`. It is the inverse of the team's 16-bit integer square-root unit and uses the same start/busy handshake and port naming. It feeds sqrt round-trip checks and any datapath that needs a small square without a hard multiplier.

## Interface
- `IN_W`, default 8: operand width.
- `OUT_W`, default 16: result width. Fixed at 2*`IN_W`.
- `clk_i` input, 1: single clock. All state changes on the rising edge.
- `rst_i` input, 1: reset, synchronous and active-high.
- `start_i` input, 1: request. Level-sampled only in IDLE.
- `x_bi` input, `IN_W`: operand. Sampled on the edge that accepts `start_i`.
- `y_bo` output, `OUT_W`: last completed square. Holds until the next completion.
- `busy_o` output, 1: high while a computation is in progress.

## Operation
- Reset values: `y_bo`=0, `busy_o`=0, state=IDLE. Internal `a`, `b`, `acc` and `cnt` are 0.
- States:
  - IDLE: `busy_o`=0.
  - WORK: `busy_o`=1.
  - Two states only, with no terminal state. The block returns to IDLE after every result.
- IDLE, when `start_i`=1:
  - `a` ← zero-extended `x_bi` (OUT_W bits).
  - `b` ← `x_bi`.
  - `acc` ← 0, `cnt` ← 0, `busy_o` ← 1.
  - Next state WORK.
- IDLE, when `start_i`=0: hold all state.
- WORK, each cycle:
  - sum = `acc` + (`b[0]` ? `a` : 0), computed mod 2^OUT_W. It cannot overflow, since the maximum is 0xFE01.
  - `acc` ← sum, `a` ← `a`<<1, `b` ← `b`>>1, `cnt` ← `cnt`+1.
- WORK termination: `cnt`==IN_W-1, or the early-exit condition below.
  - `y_bo` ← sum (the current-cycle sum, not the registered `acc`).
  - `busy_o` ← 0, next state IDLE.
- `start_i` while in WORK: ignored. `x_bi` changes during WORK have no effect.
- `start_i` held high continuously: a new operation is accepted on the first IDLE cycle after completion.
- `rst_i` in any state, including mid-WORK:
  - Returns to the reset values on that edge.
  - `y_bo` clears to 0. No partial result is ever written.
  - Reset has priority over `start_i`.

## Timing
- `start_i` accepted at edge k: `busy_o`=1 after edge k.
- Without early exit, the result is written at edge k+IN_W (k+8). `busy_o` is high for exactly IN_W cycles.
- `y_bo` is valid on the same cycle `busy_o` falls and stays stable while `busy_o`=0.
- Minimum start-to-start spacing is IN_W+1 cycles (one IDLE cycle between operations).
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `SQR_MUL_EARLY_EXIT_EN`.
- Defined:
  - WORK also terminates when (`b`>>1)==0, i.e. no remaining multiplier bits.
  - Busy duration is max(1, bit-length of x) cycles: x=0 or 1 gives 1 cycle, x=0x0C gives 4, x=0x80 gives 8.
- Undefined: fixed IN_W-cycle latency for every operand. Results are identical in both modes.

## Structure
- Package `sqr_pkg`:
  - `SQR_IN_W`=8, `SQR_OUT_W`=16.
  - Enum `sqr_state_t` {IDLE, WORK}.
  - Localparam `SQR_CNT_W` = $clog2(SQR_IN_W).
- Single module. No sub-module is warranted: the adder and shifters are one always block plus one continuous assignment for sum.

## Test plan
- Reset then idle: `rst_i` for 2 cycles → `y_bo`=0x0000, `busy_o`=0. No change while `start_i`=0.
- Corner operands: x=0x00 → 0x0000; x=0x01 → 0x0001; x=0xFF → 0xFE01; x=0x0C → 0x0090.
  - Check `busy_o` high for exactly 8 cycles without the macro.
  - With the macro, check 1, 1, 8 and 4 cycles respectively.
- Start and operand changes during busy: x=0x10 starts; `start_i` pulses at cycles 2 and 5 with x_bi=0x03 → single result 0x0100. No second busy period.
- Reset mid-operation: x=0xFF starts; `rst_i` at cycle 4 → `busy_o`=0 and `y_bo`=0 next cycle. A following start with x=0x07 → 0x0031.
- Back-to-back: `start_i` held high, x_bi=0x05 then 0x09 → 0x0019, one IDLE cycle, then 0x0051.
- Exhaustive sweep: all 256 operands compared against a x*x model. Additionally, sqrt(`y_bo`) through the sqrt unit equals x.

Source files
------------

// File: rtl/sqr_pkg.sv
// sqr_pkg: shared widths and state encoding for the iterative squarer.
package sqr_pkg;
    localparam int SQR_IN_W  = 8;
    localparam int SQR_OUT_W = 16;
    localparam int SQR_CNT_W = $clog2(SQR_IN_W);
    typedef enum logic {IDLE, WORK} sqr_state_t;
endpackage

// File: rtl/sqr_mul.sv
// sqr_mul: shift-add squarer, one multiplier bit per cycle with start/busy handshake.
// SQR_MUL_EARLY_EXIT_EN: stop as soon as no multiplier bits remain.
module sqr_mul
    import sqr_pkg::*;
#(
    parameter int IN_W  = SQR_IN_W,
    parameter int OUT_W = SQR_OUT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [IN_W-1:0]  x_bi,
    output logic [OUT_W-1:0] y_bo,
    output logic             busy_o
);
    localparam int CW = $clog2(IN_W);
    sqr_state_t state_q, state_d;
    logic [OUT_W-1:0] a_q, a_d, acc_q, acc_d, y_q, y_d, sum;
    logic [IN_W-1:0]  b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done;
    assign sum = acc_q + (b_q[0] ? a_q : '0);
`ifdef SQR_MUL_EARLY_EXIT_EN
    assign done = (cnt_q == CW'(IN_W - 1)) || ((b_q >> 1) == '0);
`else
    assign done = cnt_q == CW'(IN_W - 1);
`endif
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        if (state_q == IDLE) begin
            if (start_i) begin
                a_d     = OUT_W'(x_bi);
                b_d     = x_bi;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = WORK;
            end
        end else begin
            acc_d = sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            // result comes from this cycle's sum, not the lagging accumulator
            if (done) begin
                y_d     = sum;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end
    assign y_bo   = y_q;
    assign busy_o = state_q == WORK;
endmodule

// File: tb/tb_sqr_mul.sv
// tb_sqr_mul: directed and randomized checks of sqr_mul against an arithmetic x*x model.
module tb_sqr_mul;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  x_bi = '0;
    logic [15:0] y_bo;
    logic        busy_o;
    int total = 0;
    int passed = 0;
    int fails = 0;

    sqr_mul dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i),
        .x_bi   (x_bi),
        .y_bo   (y_bo),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_dur(input logic [7:0] x);
        int n = 0;
`ifdef SQR_MUL_EARLY_EXIT_EN
        for (int i = 0; i < 8; i++) if (x[i]) n = i + 1;
        return (n < 1) ? 1 : n;
`else
        n = 8;
        return n;
`endif
    endfunction

    function automatic int isqrt(input int v);
        int s = 0;
        for (int r = 0; r < 256; r++) if (r * r <= v) s = r;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(output int cyc, input bit noise);
        cyc = 0;
        while (busy_o && cyc < 20) begin
            if (noise) begin
                x_bi    = 8'($urandom);
                start_i = 1'($urandom);
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] x, input int gap, input bit noise);
        int cyc;
        repeat (gap) tick();
        start_i = 1'b1;
        x_bi    = x;
        tick();
        start_i = 1'b0;
        check("busy_rise", 32'(busy_o), 32'd1);
        wait_idle(cyc, noise);
        check("square", 32'(y_bo), 32'(int'(x) * int'(x)));
        check("latency", 32'(cyc), 32'(exp_dur(x)));
        check("sqrt_rt", 32'(isqrt(int'(y_bo))), 32'(x));
    endtask

    initial begin
        int cyc;
        repeat (2) tick();
        rst_i = 1'b0;
        check("rst_y", 32'(y_bo), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        repeat (3) tick();
        check("idle_y", 32'(y_bo), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);

        run_op(8'h00, 0, 1'b0);
        run_op(8'h01, 1, 1'b0);
        run_op(8'hFF, 1, 1'b0);
        run_op(8'h0C, 1, 1'b0);

        // start pulses with a new operand while busy must be ignored
        start_i = 1'b1;
        x_bi    = 8'h10;
        tick();
        start_i = 1'b0;
        cyc = 1;
        while (busy_o && cyc < 20) begin
            start_i = (cyc == 2 || cyc == 5);
            x_bi    = (cyc == 2 || cyc == 5) ? 8'h03 : 8'h10;
            tick();
            cyc++;
        end
        start_i = 1'b0;
        check("ign_y", 32'(y_bo), 32'h0100);
        check("ign_lat", 32'(cyc - 1), 32'(exp_dur(8'h10)));
        repeat (3) begin
            tick();
            check("ign_no2nd", 32'(busy_o), 32'd0);
        end

        // reset in the middle of an operation
        start_i = 1'b1;
        x_bi    = 8'hFF;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_y", 32'(y_bo), 32'd0);
        run_op(8'h07, 1, 1'b0);

        // back-to-back with start held high
        start_i = 1'b1;
        x_bi    = 8'h05;
        tick();
        x_bi = 8'h09;
        check("b2b_busy1", 32'(busy_o), 32'd1);
        cyc = 0;
        while (busy_o && cyc < 20) begin
            tick();
            cyc++;
        end
        check("b2b_y1", 32'(y_bo), 32'h0019);
        check("b2b_lat1", 32'(cyc), 32'(exp_dur(8'h05)));
        check("b2b_gap", 32'(busy_o), 32'd0);
        tick();
        start_i = 1'b0;
        check("b2b_busy2", 32'(busy_o), 32'd1);
        wait_idle(cyc, 1'b0);
        check("b2b_y2", 32'(y_bo), 32'h0051);
        check("b2b_lat2", 32'(cyc), 32'(exp_dur(8'h09)));

        for (int i = 0; i < 256; i++) run_op(8'(i), 1, 1'b1);
        for (int i = 0; i < 40; i++) run_op(8'($urandom), int'($urandom_range(1, 4)), 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
